// File: rtl/wb_cmd_master.sv
// wb_cmd_master: one-command-at-a-time Wishbone initiator.
// A command on the valid/ready port becomes one classic WB cycle. The result
// comes back on the valid/ready response port.
// Optional ACK timeout: define WB_MASTER_TIMEOUT_EN. Without it the bus phase
// waits for ACK indefinitely and rsp_err_o is tied low.
module wb_cmd_master #(
  parameter int          ADR_W          = 17,
  parameter int          DAT_W          = 32,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          TIMEOUT_W      = 5,
  parameter logic [31:0] ERR_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic             WB_CLK,
  input  logic             WB_RST,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [3:0]       cmd_be_i,
  input  logic [DAT_W-1:0] cmd_wdat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_rdat_o,
  output logic             rsp_err_o,
  output logic [ADR_W-1:0] WBm_ADR_o,
  output logic             WBm_CYC_o,
  output logic             WBm_STB_o,
  output logic             WBm_WE_o,
  output logic             WBm_RD_o,
  output logic [3:0]       WBm_BYTE_STB_o,
  output logic [DAT_W-1:0] WBm_WR_DAT_o,
  input  logic [DAT_W-1:0] WBm_RD_DAT_i,
  input  logic             WBm_ACK_i,
  output logic             busy_o,
  output logic [15:0]      txn_cnt_o
);

  // The timeout counter must be able to hold the limit value.
  if ((2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_w
    $error("wb_cmd_master: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_nx;
  logic        accept;
  logic        bus_ack;
  logic        timeout;
  logic [15:0] txn_cnt;

  assign accept   = cmd_valid_i & cmd_ready_o;
  // ACK only means something while a cycle is on the bus.
  assign bus_ack  = (state == BUS) & WBm_ACK_i;

  // CYC/STB come straight from the registered state, so they rise the cycle
  // after accept and drop the cycle after ACK (or timeout).
  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign rsp_valid_o = (state == RESP);
  assign WBm_CYC_o   = (state == BUS);
  assign WBm_STB_o   = (state == BUS);
  assign WBm_RD_o    = WBm_CYC_o & ~WBm_WE_o;
  assign txn_cnt_o   = txn_cnt;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 rsp_err_q;

  // Cycles spent in BUS without ACK; restarts with every accepted command.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST)                              to_cnt <= '0;
    else if (accept)                         to_cnt <= '0;
    else if ((state == BUS) && !WBm_ACK_i)   to_cnt <= to_cnt + TIMEOUT_W'(1);
  end

  // Limit hit this cycle with no ACK; an ACK on the last cycle still wins.
  assign timeout = (state == BUS) && !WBm_ACK_i &&
                   (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Error flag is captured alongside the response data.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST)                   rsp_err_q <= 1'b0;
    else if (bus_ack || timeout)  rsp_err_q <= ~bus_ack;
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign timeout   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)              state_nx = BUS;
      BUS:     if (bus_ack || timeout)  state_nx = RESP;
      RESP:    if (rsp_ready_i)         state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  // Bus-side command fields latch at accept and hold through the bus phase.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      WBm_ADR_o      <= '0;
      WBm_WE_o       <= 1'b0;
      WBm_BYTE_STB_o <= '0;
      WBm_WR_DAT_o   <= '0;
    end else if (accept) begin
      WBm_ADR_o      <= cmd_adr_i;
      WBm_WE_o       <= cmd_we_i;
      WBm_BYTE_STB_o <= cmd_be_i;
      WBm_WR_DAT_o   <= cmd_wdat_i;
    end
  end

  // Response data: slave data on a read ACK, error pattern on a read timeout,
  // zero for any write. Held until the next bus completion.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST)
      rsp_rdat_o <= '0;
    else if (bus_ack || timeout)
      rsp_rdat_o <= WBm_WE_o ? '0 : (bus_ack ? WBm_RD_DAT_i : DAT_W'(ERR_READ_VALUE));
  end

  // Completed responses, timed-out ones included; wraps naturally.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST)                          txn_cnt <= '0;
    else if (rsp_valid_o && rsp_ready_i) txn_cnt <= txn_cnt + 16'd1;
  end

endmodule
